// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam int unsigned DEFAULT_DIVISOR = 868;

  // Assemble the STATUS read word from its fields.
  function automatic logic [31:0] pack_status(input logic [7:0] cnt, input logic ovf,
                                              input logic busy, input logic empty,
                                              input logic full);
    logic [31:0] s;
    s                            = 32'h0;
    s[STAT_CNT_LSB +: 8]         = cnt;
    s[STAT_OVF]                  = ovf;
    s[STAT_BUSY]                 = busy;
    s[STAT_EMPTY]                = empty;
    s[STAT_FULL]                 = full;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART register window.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        sel;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input sel, input rdata);
  modport slave  (input addr, input wdata, input we, output sel, output rdata);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign dout  = r_mem[r_rd];
  assign count = r_cnt;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter and frame FSM.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1002_0000,
  parameter int unsigned DIVISOR    = DEFAULT_DIVISOR,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk_in,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          irq_empty
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e   r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_irq;
  logic          r_ovf;

  logic          w_sel;
  logic [1:0]    w_ofs;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_ovf_clr;
  logic          w_pop;
  logic          w_busy;
  logic          w_baud_tc;
  logic          w_idle_next;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_dout;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_next;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_sel      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs      = bus.addr[3:2];
  assign w_push_req = bus.we & w_sel & (w_ofs == OFS_TXDATA);
  assign w_push_ok  = w_push_req & ~w_full;
  assign w_ovf_clr  = bus.we & w_sel & (w_ofs == OFS_STATUS) & bus.wdata[STAT_OVF];
  assign w_busy     = (r_state != ST_IDLE);
  assign w_baud_tc  = (r_baud == 16'(DIVISOR - 1));
  assign w_unused   = &{1'b0, bus.wdata[31:8], bus.addr[1:0]};

  // The FSM pops when idle, or at the end of a stop bit to chain frames without a gap.
  assign w_pop       = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_tc));
  assign w_idle_next = w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_tc));
  assign w_cnt_next  = w_count + CW'(w_push_ok) - CW'(w_pop);

  assign w_status  = pack_status(8'(w_count), r_ovf, w_busy, w_empty, w_full);
  assign bus.sel   = w_sel;
  assign bus.rdata = (w_sel && (w_ofs == OFS_STATUS)) ? w_status : 32'h0;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (w_push_req),
    .pop    (w_pop),
    .din    (bus.wdata[7:0]),
    .dout   (w_dout),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_irq   <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_baud <= w_baud_tc ? 16'h0 : r_baud + 16'h1;
      r_irq  <= w_idle_next & (w_cnt_next == '0);
      // A dropped byte wins over a same-cycle clear.
      if (w_push_req & w_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)      r_ovf <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift <= w_dout;
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_tc) begin
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_baud_tc) begin
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_baud_tc) begin
            if (!w_empty) begin
              r_shift <= w_dout;
              r_tx    <= 1'b0;
              r_baud  <= '0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx        = r_tx;
  assign irq_empty = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode table, directed frame sequences and random traffic vs a frame-level model.
module tb_mmio_uart_tx;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h1002_0000;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic irq;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .DIVISOR    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in    (clk),
    .reset     (rst),
    .bus       (bus),
    .tx        (tx),
    .irq_empty (irq)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Frame-level reference: a byte queue plus the start cycle of the frame on the wire.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_active;
  int         m_fstart;
  int         m_cyc;
  logic [7:0] m_byte;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic model_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = (m_cyc - m_fstart) / D;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic [31:0] model_status();
    return {16'h0, 8'(q.size()), 4'h0, m_ovf, m_active, q.size() == 0, q.size() == DEPTH};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf    = 0;
    m_active = 0;
    m_fstart = 0;
    m_cyc    = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
    bit in_win;
    bit full_pre;
    in_win   = (a[31:4] == BASE[31:4]);
    full_pre = (q.size() == DEPTH);
    m_cyc++;
    if (m_active && (m_cyc - m_fstart) >= 10 * D) m_active = 0;
    if (!m_active && q.size() != 0) begin
      m_byte   = q.pop_front();
      m_active = 1;
      m_fstart = m_cyc;
    end
    if (w && in_win && a[3:2] == 2'd0) begin
      if (full_pre) m_ovf = 1;
      else q.push_back(d[7:0]);
    end
    if (w && in_win && a[3:2] == 2'd1 && d[3]) m_ovf = 0;
  endtask

  // Called just after a falling edge; leaves the bus pointed at STATUS.
  task automatic compare();
    bus.we   = 1'b0;
    bus.addr = BASE + 32'h4;
    #1;
    chk("status", bus.rdata, model_status());
    chk("tx", 32'(tx), 32'(model_tx()));
    chk("irq_empty", 32'(irq), 32'(q.size() == 0 && !m_active));
  endtask

  task automatic cycle(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.addr  = a;
    bus.we    = w;
    bus.wdata = d;
    @(posedge clk);
    model_edge(a, w, d);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.we = 1'b0;
    rst    = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        sel;
    logic [31:0] rdata;
  } vec_t;

  initial begin
    vec_t       tv[8];
    logic [9:0] fr1;
    logic [9:0] fr2;
    logic       e;

    rst       = 1'b1;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    model_reset();
    do_reset();
    chk("reset_status", bus.rdata, 32'h0000_0002);
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_irq", 32'(irq), 32'h1);

    // Address decode table (loads only, idle block).
    tv[0] = '{BASE,                 1'b1, 32'h0};
    tv[1] = '{BASE + 32'h4,         1'b1, 32'h2};
    tv[2] = '{BASE + 32'h8,         1'b1, 32'h0};
    tv[3] = '{BASE + 32'hC,         1'b1, 32'h0};
    tv[4] = '{BASE + 32'h10,        1'b0, 32'h0};
    tv[5] = '{BASE + 32'h7,         1'b1, 32'h2};
    tv[6] = '{BASE - 32'h4,         1'b0, 32'h0};
    tv[7] = '{32'h0000_0004,        1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      bus.we   = 1'b0;
      bus.addr = tv[i].addr;
      #1;
      chk($sformatf("sel[%0d]", i), 32'(bus.sel), 32'(tv[i].sel));
      chk($sformatf("rdata[%0d]", i), bus.rdata, tv[i].rdata);
      @(posedge clk);
      model_edge(tv[i].addr, 1'b0, 32'h0);
      @(negedge clk);
    end

    // Stores outside the window and to reserved offsets change nothing.
    cycle(BASE + 32'h10, 1'b1, 32'hAA);
    chk("oow_status", bus.rdata, 32'h2);
    cycle(BASE + 32'h8, 1'b1, 32'hFFFF_FFFF);
    cycle(BASE + 32'hC, 1'b1, 32'h55);
    for (int i = 0; i < 4; i++) cycle(BASE, 1'b0, 32'h0);
    chk("rsv_status", bus.rdata, 32'h2);
    chk("rsv_tx", 32'(tx), 32'h1);

    // Single 0x55 frame.
    fr1 = {1'b1, 8'h55, 1'b0};
    cycle(BASE, 1'b1, 32'h55);
    chk("w55_tx_n", 32'(tx), 32'h1);
    for (int i = 1; i <= 44; i++) begin
      cycle(BASE, 1'b0, 32'h0);
      e = (i <= 40) ? fr1[(i-1)/4] : 1'b1;
      chk($sformatf("w55_tx[%0d]", i), 32'(tx), 32'(e));
      chk($sformatf("w55_busy[%0d]", i), 32'(bus.rdata[2]), 32'(i <= 40));
    end
    chk("w55_irq_after", 32'(irq), 32'h1);

    // Back-to-back 0x41, 0x42; second write lands on the pop edge.
    fr1 = {1'b1, 8'h41, 1'b0};
    fr2 = {1'b1, 8'h42, 1'b0};
    cycle(BASE, 1'b1, 32'h41);
    cycle(BASE, 1'b1, 32'h42);
    chk("b2b_cnt0", 32'(bus.rdata[15:8]), 32'h1);
    for (int k = 1; k <= 84; k++) begin
      cycle(BASE, 1'b0, 32'h0);
      e = (k < 40) ? fr1[k/4] : (k < 80) ? fr2[(k-40)/4] : 1'b1;
      chk($sformatf("b2b_tx[%0d]", k), 32'(tx), 32'(e));
      if (k == 10) chk("b2b_cnt10", 32'(bus.rdata[15:8]), 32'h1);
    end

    // Overflow on a depth-4 FIFO.
    for (int i = 0; i < 6; i++) cycle(BASE, 1'b1, 32'(8'hA0 + i));
    chk("ovf_status", bus.rdata, 32'h0000_040D);
    cycle(BASE + 32'h4, 1'b1, 32'h8);
    chk("ovf_clear", bus.rdata, 32'h0000_0405);
    for (int i = 0; i < 220; i++) cycle(BASE, 1'b0, 32'h0);
    chk("ovf_drained", bus.rdata, 32'h2);

    // Reset during data bit 3.
    cycle(BASE, 1'b1, 32'h3C);
    for (int i = 0; i < 18; i++) cycle(BASE, 1'b0, 32'h0);
    chk("pre_rst_tx", 32'(tx), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx), 32'h1);
    chk("async_rst_status", bus.rdata, 32'h2);
    chk("async_rst_irq", 32'(irq), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare();
    for (int i = 0; i < 50; i++) cycle(BASE, 1'b0, 32'h0);
    chk("post_rst_tx", 32'(tx), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 6)       cycle(BASE, 1'b1, $urandom);
      else if (r < 8)  cycle(BASE + 32'h4, 1'b1, $urandom);
      else if (r < 9)  cycle(BASE + 32'(4 * $urandom_range(2, 3)), 1'b1, $urandom);
      else if (r < 10) cycle(BASE + 32'h10 + 32'($urandom_range(0, 255)), 1'b1, $urandom);
      else             cycle($urandom, 1'b0, $urandom);
    end
    for (int i = 0; i < 300; i++) cycle(BASE, 1'b0, 32'h0);
    chk("final_status", bus.rdata & 32'hFFFF_FFF7, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
